// File: rtl/sdr_arb_pkg.sv
// rtl/sdr_arb_pkg.sv - shared types and helpers for the SDRAM request-path arbiters
//
// Purpose: state encoding for the burst arbiters, the rotate-priority
// winner search shared by rr_pick, and the requester-ID width helper.
// Ports: none (package).
package sdr_arb_pkg;

  // Widest requester set any arbiter built on this package supports.
  localparam int MAX_N  = 8;
  localparam int MAX_IW = 3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_XFER = 1'b1
  } arb_state_t;

  typedef struct packed {
    logic              valid;
    logic [MAX_IW-1:0] id;
  } pick_t;

  // Requester-ID width for n requesters; never narrower than one bit.
  function automatic int id_width(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  // First requester with req set, searching from last+1 and wrapping modulo n.
  // The loop runs from the far end down so the nearest candidate is written
  // last and therefore wins. The modulo keeps candidates below n, so for a
  // non-power-of-2 n the unused IDs are never produced.
  function automatic pick_t rr_search(input logic [MAX_N-1:0]  req,
                                      input int                n,
                                      input logic [MAX_IW-1:0] last);
    pick_t             res;
    logic [MAX_IW-1:0] cand;
    res = '0;
    for (int k = MAX_N; k >= 1; k--) begin
      if (k <= n) begin
        cand = MAX_IW'((int'(last) + k) % n);
        if (req[cand]) begin
          res.valid = 1'b1;
          res.id    = cand;
        end
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/rr_pick.sv
// rtl/rr_pick.sv - combinational rotate-priority encoder
//
// Purpose: picks the next requester after 'last' in cyclic order; shared by
// the write- and read-side burst arbiters.
// Ports:
//   req    in  N   request vector
//   last   in  IW  previously granted ID; search starts at last+1
//   valid  out 1   at least one request is pending
//   winner out IW  selected requester (meaningful only when valid)
module rr_pick
  import sdr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic          valid,
  output logic [IW-1:0] winner
);

  pick_t pick;

  always_comb begin
    pick   = rr_search(MAX_N'(req), N, MAX_IW'(last));
    valid  = pick.valid;
    winner = IW'(pick.id);
  end

endmodule

// File: rtl/fifo_wr_arb.sv
// rtl/fifo_wr_arb.sv - round-robin burst arbiter feeding one shared write FIFO
//
// Purpose: grants one requester at a time for a whole burst and pushes its
// beats into the FIFO tagged with the requester ID, never writing while full.
// Ports:
//   clk, reset_n   clock, asynchronous active-low reset
//   req[N]         burst request per requester, held until its last beat is acked
//   req_len[N*LW]  burst length minus one per requester (slice i = [i*LW +: LW])
//   req_data[N*W]  current beat data per requester (slice i = [i*W +: W])
//   ack[N]         one-hot beat accept; requester advances its data on it
//   fifo_full      registered full flag from the FIFO
//   fifo_wr_en     FIFO write strobe
//   fifo_wr_data   {grant ID, beat data}
//   busy           high while a burst is in progress
//   cur_id         current or most recently granted requester
module fifo_wr_arb
  import sdr_arb_pkg::*;
#(
  parameter int N  = 4,
  parameter int W  = 32,
  parameter int LW = 4,
  parameter int IW = id_width(N)
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [N-1:0]    req,
  input  logic [N*LW-1:0] req_len,
  input  logic [N*W-1:0]  req_data,
  output logic [N-1:0]    ack,
  input  logic            fifo_full,
  output logic            fifo_wr_en,
  output logic [IW+W-1:0] fifo_wr_data,
  output logic            busy,
  output logic [IW-1:0]   cur_id
);

  arb_state_t    state;
  arb_state_t    state_nx;
  logic [LW-1:0] cnt;
  logic          pick_valid;
  logic [IW-1:0] pick_id;

  logic [W-1:0]  beat_data [N];
  logic [LW-1:0] beat_len  [N];

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign beat_data[g] = req_data[g*W +: W];
    assign beat_len[g]  = req_len[g*LW +: LW];
  end

  rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req    (req),
    .last   (cur_id),
    .valid  (pick_valid),
    .winner (pick_id)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_IDLE: if (pick_valid) state_nx = ST_XFER;
      ST_XFER: if (fifo_wr_en && cnt == '0) state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  // A beat is accepted on every XFER cycle the FIFO has room; the ack to the
  // owner is the write strobe itself so data advances in lockstep with writes.
  always_comb begin
    fifo_wr_en = 1'b0;
    ack        = '0;
    busy       = 1'b0;
    if (state == ST_XFER) begin
      busy        = 1'b1;
      fifo_wr_en  = !fifo_full;
      ack[cur_id] = !fifo_full;
    end
    fifo_wr_data = {cur_id, beat_data[cur_id]};
  end

  // cur_id resets to the last ID so requester 0 wins the first arbitration.
  // req_len is captured only at grant time; the burst is locked afterwards.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cur_id <= IW'(N - 1);
      cnt    <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pick_valid) begin
            cur_id <= pick_id;
            cnt    <= beat_len[pick_id];
          end
        end
        ST_XFER: begin
          if (fifo_wr_en && cnt != '0) cnt <= cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

`ifndef SYNTHESIS
  a_req_held: assert property (@(posedge clk) disable iff (!reset_n)
    (state == ST_XFER) |-> req[cur_id]);
  a_no_write_full: assert property (@(posedge clk) disable iff (!reset_n)
    !(fifo_wr_en && fifo_full));
  a_ack_onehot: assert property (@(posedge clk) disable iff (!reset_n)
    $onehot0(ack));
`endif

endmodule

// File: tb/tb_fifo_wr_arb.sv
// tb/tb_fifo_wr_arb.sv - self-checking bench for fifo_wr_arb
module tb_fifo_wr_arb;

  localparam int N  = 4;
  localparam int W  = 32;
  localparam int LW = 4;
  localparam int IW = 2;
  localparam int N3 = 3;
  localparam int W3 = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            reset_n;
  logic [N-1:0]    req;
  logic [N*LW-1:0] req_len;
  logic [N*W-1:0]  req_data;
  logic [N-1:0]    ack;
  logic            fifo_full;
  logic            fifo_wr_en;
  logic [IW+W-1:0] fifo_wr_data;
  logic            busy;
  logic [IW-1:0]   cur_id;

  logic [N3-1:0]    req3;
  logic [N3*LW-1:0] req_len3;
  logic [N3*W3-1:0] req_data3;
  logic [N3-1:0]    ack3;
  logic             full3;
  logic             wr3;
  logic [IW+W3-1:0] wdata3;
  logic             busy3;
  logic [IW-1:0]    cur3;

  fifo_wr_arb #(.N(N), .W(W), .LW(LW), .IW(IW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req),
    .req_len      (req_len),
    .req_data     (req_data),
    .ack          (ack),
    .fifo_full    (fifo_full),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .busy         (busy),
    .cur_id       (cur_id)
  );

  fifo_wr_arb #(.N(N3), .W(W3), .LW(LW), .IW(IW)) dut3 (
    .clk          (clk),
    .reset_n      (reset_n),
    .req          (req3),
    .req_len      (req_len3),
    .req_data     (req_data3),
    .ack          (ack3),
    .fifo_full    (full3),
    .fifo_wr_en   (wr3),
    .fifo_wr_data (wdata3),
    .busy         (busy3),
    .cur_id       (cur3)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h @%0t", name, act, exp, $time);
    end
  endtask

  logic [23:0] seq [N];

  task automatic drive_data();
    for (int i = 0; i < N; i++) req_data[i*W +: W] = {8'(i), seq[i]};
  endtask

  function automatic int rr_model(input logic [N-1:0] r, input int last);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last + k) % N;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  typedef struct {
    bit         rst;
    logic [3:0] rq;
    logic [3:0] ln;
    bit         full;
    bit         wr;
    logic [3:0] ak;
    logic [1:0] id;
    bit         bsy;
    int         sq;
  } vec_t;

  vec_t vecs[$];

  function automatic void row(input bit rst, input logic [3:0] rq, input logic [3:0] ln,
                              input bit full, input bit wr, input logic [3:0] ak,
                              input logic [1:0] id, input bit bsy, input int sq);
    vec_t v;
    v.rst = rst; v.rq = rq; v.ln = ln; v.full = full; v.wr = wr;
    v.ak = ak; v.id = id; v.bsy = bsy; v.sq = sq;
    vecs.push_back(v);
  endfunction

  task automatic rst_row();
    row(1, 4'b0000, 4'd0, 0, 0, 4'b0000, 2'd3, 0, 0);
  endtask

  initial begin
    int g;
    int prev;
    int nwr;
    bit          act  [N];
    int          left [N];
    logic [3:0]  lens [N];
    bit          m_busy;
    int          m_owner;
    int          m_left;
    int          m_last;
    bit          exp_wr;
    logic [3:0]  exp_ack;
    int          w;

    reset_n   = 1'b0;
    req       = '0;
    req_len   = '0;
    fifo_full = 1'b0;
    req3      = '0;
    req_len3  = '0;
    req_data3 = {8'hA2, 8'hA1, 8'hA0};
    full3     = 1'b0;
    for (int i = 0; i < N; i++) seq[i] = '0;
    drive_data();

    // reset state
    rst_row();
    rst_row();
    // single 4-beat burst from requester 0
    row(0, 4'b0001, 4'd3, 0, 0, 4'b0000, 2'd3, 0, 0);
    for (int k = 0; k < 4; k++) row(0, 4'b0001, 4'd3, 0, 1, 4'b0001, 2'd0, 1, k);
    row(0, 4'b0000, 4'd3, 0, 0, 4'b0000, 2'd0, 0, 0);
    // all requesting, single-beat bursts
    rst_row();
    row(0, 4'b1111, 4'd0, 0, 0, 4'b0000, 2'd3, 0, 0);
    for (int k = 0; k < 6; k++) begin
      g = k % 4;
      row(0, 4'b1111, 4'd0, 0, 1, 4'(1 << g), 2'(g), 1, k / 4);
      row(0, 4'b1111, 4'd0, 0, 0, 4'b0000, 2'(g), 0, 0);
    end
    // 0101 after a burst by requester 0
    rst_row();
    row(0, 4'b0001, 4'd0, 0, 0, 4'b0000, 2'd3, 0, 0);
    row(0, 4'b0001, 4'd0, 0, 1, 4'b0001, 2'd0, 1, 0);
    prev = 0;
    for (int k = 0; k < 4; k++) begin
      g = (k % 2 == 0) ? 2 : 0;
      row(0, 4'b0101, 4'd0, 0, 0, 4'b0000, 2'(prev), 0, 0);
      row(0, 4'b0101, 4'd0, 0, 1, 4'(1 << g), 2'(g), 1, (g == 2) ? k / 2 : (k + 1) / 2);
      prev = g;
    end
    // 3-beat burst with a 3-cycle full stall on the 2nd beat
    rst_row();
    row(0, 4'b0010, 4'd2, 0, 0, 4'b0000, 2'd3, 0, 0);
    row(0, 4'b0010, 4'd2, 0, 1, 4'b0010, 2'd1, 1, 0);
    for (int k = 0; k < 3; k++) row(0, 4'b0010, 4'd2, 1, 0, 4'b0000, 2'd1, 1, 0);
    row(0, 4'b0010, 4'd2, 0, 1, 4'b0010, 2'd1, 1, 1);
    row(0, 4'b0010, 4'd2, 0, 1, 4'b0010, 2'd1, 1, 2);
    row(0, 4'b0000, 4'd2, 0, 0, 4'b0000, 2'd1, 0, 0);
    // reset during the 2nd beat of an 8-beat burst, then a fresh burst
    rst_row();
    row(0, 4'b1000, 4'd7, 0, 0, 4'b0000, 2'd3, 0, 0);
    row(0, 4'b1000, 4'd7, 0, 1, 4'b1000, 2'd3, 1, 0);
    row(1, 4'b1000, 4'd7, 0, 0, 4'b0000, 2'd3, 0, 0);
    row(0, 4'b1000, 4'd7, 0, 0, 4'b0000, 2'd3, 0, 0);
    for (int k = 0; k < 8; k++) row(0, 4'b1000, 4'd7, 0, 1, 4'b1000, 2'd3, 1, k);
    row(0, 4'b0000, 4'd7, 0, 0, 4'b0000, 2'd3, 0, 0);

    foreach (vecs[v]) begin
      @(negedge clk);
      reset_n = !vecs[v].rst;
      if (vecs[v].rst) for (int i = 0; i < N; i++) seq[i] = '0;
      req       = vecs[v].rq;
      req_len   = {N{vecs[v].ln}};
      fifo_full = vecs[v].full;
      drive_data();
      #1;
      chk($sformatf("tbl%0d_wr_en", v), 64'(fifo_wr_en), 64'(vecs[v].wr));
      chk($sformatf("tbl%0d_ack", v), 64'(ack), 64'(vecs[v].ak));
      chk($sformatf("tbl%0d_busy", v), 64'(busy), 64'(vecs[v].bsy));
      chk($sformatf("tbl%0d_cur_id", v), 64'(cur_id), 64'(vecs[v].id));
      chk($sformatf("tbl%0d_wr_full", v), 64'(fifo_wr_en & fifo_full), 64'(0));
      if (vecs[v].wr)
        chk($sformatf("tbl%0d_data", v), 64'(fifo_wr_data),
            64'({vecs[v].id, 8'(vecs[v].id), 24'(vecs[v].sq)}));
      for (int i = 0; i < N; i++) if (vecs[v].ak[i]) seq[i]++;
    end

    // N=3 build: cyclic order must skip ID 3
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    @(negedge clk);
    reset_n = 1'b1;
    nwr = 0;
    for (int c = 0; c <= 16; c++) begin
      int eid;
      req3 = (c < 16) ? 3'b111 : 3'b000;
      #1;
      exp_wr = (c % 2 == 1);
      eid    = (c / 2) % 3;
      chk($sformatf("n3_c%0d_wr", c), 64'(wr3), 64'(exp_wr));
      chk($sformatf("n3_c%0d_busy", c), 64'(busy3), 64'(exp_wr));
      if (wr3) begin
        nwr++;
        chk($sformatf("n3_c%0d_id_range", c), 64'(wdata3[W3 +: IW] < 2'd3), 64'(1));
      end
      if (exp_wr) begin
        chk($sformatf("n3_c%0d_data", c), 64'(wdata3), 64'({2'(eid), 8'(8'hA0 + eid)}));
        chk($sformatf("n3_c%0d_ack", c), 64'(ack3), 64'(1 << eid));
      end else begin
        chk($sformatf("n3_c%0d_cur", c), 64'(cur3), 64'((c == 0) ? 2 : (c / 2 - 1) % 3));
      end
      @(negedge clk);
    end
    chk("n3_write_count", 64'(nwr), 64'(8));

    // randomized traffic against the transaction model
    reset_n = 1'b0;
    req     = '0;
    for (int i = 0; i < N; i++) begin
      seq[i] = '0; act[i] = 0; left[i] = 0; lens[i] = '0;
    end
    @(negedge clk);
    reset_n = 1'b1;
    m_busy  = 0;
    m_owner = 0;
    m_left  = 0;
    m_last  = N - 1;
    repeat (3000) begin
      @(negedge clk);
      for (int i = 0; i < N; i++) begin
        if (!act[i] && $urandom_range(0, 3) == 0) begin
          act[i]  = 1;
          lens[i] = 4'($urandom_range(0, 15));
          left[i] = int'(lens[i]) + 1;
        end
        req[i] = act[i];
        if (act[i] && !(m_busy && m_owner == i)) req_len[i*LW +: LW] = lens[i];
        else req_len[i*LW +: LW] = 4'($urandom);
      end
      fifo_full = ($urandom_range(0, 3) == 0);
      drive_data();
      #1;
      exp_wr  = m_busy && !fifo_full;
      exp_ack = exp_wr ? 4'(1 << m_owner) : 4'b0000;
      chk("rnd_wr_en", 64'(fifo_wr_en), 64'(exp_wr));
      chk("rnd_ack", 64'(ack), 64'(exp_ack));
      chk("rnd_busy", 64'(busy), 64'(m_busy));
      chk("rnd_cur_id", 64'(cur_id), 64'(m_last));
      if (exp_wr)
        chk("rnd_data", 64'(fifo_wr_data), 64'({2'(m_owner), 8'(m_owner), seq[m_owner]}));
      if (!m_busy) begin
        w = rr_model(req, m_last);
        if (w >= 0) begin
          m_busy  = 1;
          m_owner = w;
          m_last  = w;
          m_left  = int'(req_len[w*LW +: LW]) + 1;
        end
      end else if (exp_wr) begin
        seq[m_owner]++;
        left[m_owner]--;
        if (left[m_owner] == 0) act[m_owner] = 0;
        m_left--;
        if (m_left == 0) m_busy = 0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
